// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/funct constants, ALUOp codes and the ID/EX control bundle
// for the pipelined control unit and its reusable decoder.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MUL   = 6'h1c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  // Low three ALUOp bits; bit 3 is always the opcode LSB.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_BEQ  = 3'b001;
  localparam logic [2:0] ALU_R    = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_ANDI = 3'b100;
  localparam logic [2:0] ALU_SLTI = 3'b101;
  localparam logic [2:0] ALU_BNE  = 3'b110;
  localparam logic [2:0] ALU_BGTZ = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src1;
    logic       alu_src2;
    logic       ext_op;
    logic       lu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic op_reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SW) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational MIPS instruction decoder producing a ctrl_bundle_t;
// shared between the single-cycle and pipelined control units.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic         valid_i,
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t ctrl_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       isR;
  logic       isJr;
  logic [2:0] aluLow;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign isR   = (op == OP_RTYPE);
  assign isJr  = isR && (funct == FN_JR);

  always_comb begin
    case (op)
      OP_RTYPE:         aluLow = ALU_R;
      OP_BEQ:           aluLow = ALU_BEQ;
      OP_BNE:           aluLow = ALU_BNE;
      OP_ANDI:          aluLow = ALU_ANDI;
      OP_MUL:           aluLow = ALU_MUL;
      OP_SLTI, OP_SLTIU: aluLow = ALU_SLTI;
      OP_BGTZ:          aluLow = ALU_BGTZ;
      default:          aluLow = ALU_ADD;
    endcase
  end

  // An invalid slot decodes to the bubble so it can never look like a consumer.
  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    if (valid_i) begin
      ctrl_o.valid     = 1'b1;
      ctrl_o.branch    = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ);
      ctrl_o.reg_write = !(isJr || (op == OP_J) || (op == OP_BEQ) ||
                           (op == OP_BNE) || (op == OP_BGTZ) || (op == OP_SW));
      ctrl_o.mem_read  = (op == OP_LW);
      ctrl_o.mem_write = (op == OP_SW);
      ctrl_o.alu_src1  = isR && ((funct == FN_SLL) || (funct == FN_SRL) ||
                                 (funct == FN_SRA));
      ctrl_o.alu_src2  = !(isR || (op == OP_BEQ) || (op == OP_BNE) ||
                           (op == OP_MUL));
      ctrl_o.ext_op    = (op != OP_ANDI);
      ctrl_o.lu_op     = (op == OP_LUI);
      if (op == OP_JAL)
        ctrl_o.reg_dst = 2'd2;
      else if (isR || (op == OP_MUL))
        ctrl_o.reg_dst = 2'd1;
      if (op == OP_LW)
        ctrl_o.mem_to_reg = 2'd1;
      else if (op == OP_JAL)
        ctrl_o.mem_to_reg = 2'd2;
      ctrl_o.alu_op    = {op[0], aluLow};
      ctrl_o.rs        = instr_i[25:21];
      ctrl_o.rt        = instr_i[20:16];
      ctrl_o.rd        = instr_i[15:11];
      ctrl_o.shamt     = instr_i[10:6];
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode into the ID/EX register plus load-use,
// branch/jump flush and multi-cycle mul hold (PIPE_CTRL_MUL_MULTICYCLE_EN).
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int ALUOP_W    = 4,
  parameter int REG_W      = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic               ex_branch_taken,
  output logic [1:0]         pc_src,
  output logic               stall,
  output logic               flush_if_id,
  output logic               ex_valid,
  output logic               ex_branch,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src1,
  output logic               ex_alu_src2,
  output logic               ex_ext_op,
  output logic               ex_lu_op,
  output logic [1:0]         ex_reg_dst,
  output logic [1:0]         ex_mem_to_reg,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_rd,
  output logic [4:0]         ex_shamt
);

  ctrl_bundle_t idCtrl;
  ctrl_bundle_t exCtrl_q;
  ctrl_bundle_t exCtrl_d;

  logic [5:0] idOp;
  logic [5:0] idFunct;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       idJr;
  logic       idJump;
  logic       loadUse;
  logic       branchFlush;
  logic       mulHold;

  assign idOp    = id_instr[31:26];
  assign idFunct = id_instr[5:0];
  assign idRs    = id_instr[25:21];
  assign idRt    = id_instr[20:16];
  assign idJr    = id_valid && (idOp == OP_RTYPE) && (idFunct == FN_JR);
  assign idJump  = idJr || (id_valid && ((idOp == OP_J) || (idOp == OP_JAL)));

  ctrl_decode u_decode (
    .valid_i (id_valid),
    .instr_i (id_instr),
    .ctrl_o  (idCtrl)
  );

  assign branchFlush = exCtrl_q.valid && exCtrl_q.branch && ex_branch_taken;

  assign loadUse = id_valid && exCtrl_q.valid && exCtrl_q.mem_read &&
                   (exCtrl_q.rt != 5'd0) &&
                   ((exCtrl_q.rt == idRs) ||
                    (op_reads_rt(idOp) && (exCtrl_q.rt == idRt)));

`ifdef PIPE_CTRL_MUL_MULTICYCLE_EN
  mul_state_e mulState_q;
  mul_state_e mulState_d;
  logic [3:0] mulCnt_q;
  logic [3:0] mulCnt_d;
  logic       idMul;

  assign idMul   = id_valid && (idOp == OP_MUL);
  assign mulHold = (mulState_q == MUL_BUSY);

  // The FSM arms on the edge that actually loads a mul into ID/EX.
  always_comb begin
    mulState_d = mulState_q;
    mulCnt_d   = mulCnt_q;
    if (branchFlush) begin
      mulState_d = MUL_IDLE;
      mulCnt_d   = 4'd0;
    end else if (mulHold) begin
      if (mulCnt_q <= 4'd1) begin
        mulState_d = MUL_IDLE;
        mulCnt_d   = 4'd0;
      end else begin
        mulCnt_d = mulCnt_q - 4'd1;
      end
    end else if (!loadUse && idMul && (MUL_CYCLES > 1)) begin
      mulState_d = MUL_BUSY;
      mulCnt_d   = 4'(MUL_CYCLES - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mulState_q <= MUL_IDLE;
      mulCnt_q   <= 4'd0;
    end else begin
      mulState_q <= mulState_d;
      mulCnt_q   <= mulCnt_d;
    end
  end
`else
  logic unusedMulCycles;
  assign unusedMulCycles = ^4'(MUL_CYCLES);
  assign mulHold         = 1'b0;
`endif

  // Hazard resolution in priority order; reset is handled in the register.
  always_comb begin
    exCtrl_d    = idCtrl;
    stall       = 1'b0;
    flush_if_id = 1'b0;
    if (branchFlush) begin
      exCtrl_d    = CTRL_BUBBLE;
      flush_if_id = 1'b1;
    end else if (mulHold) begin
      exCtrl_d = exCtrl_q;
      stall    = 1'b1;
    end else if (loadUse) begin
      exCtrl_d = CTRL_BUBBLE;
      stall    = 1'b1;
    end else if (idJump) begin
      flush_if_id = 1'b1;
    end
  end

  always_comb begin
    pc_src = 2'b00;
    if (!stall) begin
      if (idJr)
        pc_src = 2'b10;
      else if (idJump)
        pc_src = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      exCtrl_q <= CTRL_BUBBLE;
    else
      exCtrl_q <= exCtrl_d;
  end

  assign ex_valid      = exCtrl_q.valid;
  assign ex_branch     = exCtrl_q.branch;
  assign ex_reg_write  = exCtrl_q.reg_write;
  assign ex_mem_read   = exCtrl_q.mem_read;
  assign ex_mem_write  = exCtrl_q.mem_write;
  assign ex_alu_src1   = exCtrl_q.alu_src1;
  assign ex_alu_src2   = exCtrl_q.alu_src2;
  assign ex_ext_op     = exCtrl_q.ext_op;
  assign ex_lu_op      = exCtrl_q.lu_op;
  assign ex_reg_dst    = exCtrl_q.reg_dst;
  assign ex_mem_to_reg = exCtrl_q.mem_to_reg;
  assign ex_alu_op     = ALUOP_W'(exCtrl_q.alu_op);
  assign ex_rs         = REG_W'(exCtrl_q.rs);
  assign ex_rt         = REG_W'(exCtrl_q.rt);
  assign ex_rd         = REG_W'(exCtrl_q.rd);
  assign ex_shamt      = exCtrl_q.shamt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed instruction stream with
// hand-computed per-cycle expectations, checked by a separate monitor.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_branch_taken;
  logic [1:0]  pc_src;
  logic        stall;
  logic        flush_if_id;
  logic        ex_valid, ex_branch, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_alu_src1, ex_alu_src2, ex_ext_op, ex_lu_op;
  logic [1:0]  ex_reg_dst, ex_mem_to_reg;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic [1:0]  pc;
    logic [36:0] ex;
  } exp_t;

  exp_t scoreQ[$];

  pipe_ctrl_unit #(.MUL_CYCLES(4), .ALUOP_W(4), .REG_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .ex_branch_taken (ex_branch_taken),
    .pc_src          (pc_src),
    .stall           (stall),
    .flush_if_id     (flush_if_id),
    .ex_valid        (ex_valid),
    .ex_branch       (ex_branch),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_alu_src1     (ex_alu_src1),
    .ex_alu_src2     (ex_alu_src2),
    .ex_ext_op       (ex_ext_op),
    .ex_lu_op        (ex_lu_op),
    .ex_reg_dst      (ex_reg_dst),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_alu_op       (ex_alu_op),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_shamt        (ex_shamt)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] exv(input logic v, br, rw, mr, mw, s1, s2, ext, lu,
                                      input logic [1:0] rdst, m2r,
                                      input logic [3:0] alu,
                                      input logic [4:0] rs, rt, rd, sh);
    return {v, br, rw, mr, mw, s1, s2, ext, lu, rdst, m2r, alu, rs, rt, rd, sh};
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [36:0] act;
    act = {ex_valid, ex_branch, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_alu_src1, ex_alu_src2, ex_ext_op, ex_lu_op, ex_reg_dst,
           ex_mem_to_reg, ex_alu_op, ex_rs, ex_rt, ex_rd, ex_shamt};
    checks++;
    if (stall !== e.stall || flush_if_id !== e.flush || pc_src !== e.pc || act !== e.ex) begin
      failures++;
      $display("[TB] FAIL %s: got stall=%b flush=%b pc_src=%b ex=%h, expected stall=%b flush=%b pc_src=%b ex=%h",
               e.name, stall, flush_if_id, pc_src, act, e.stall, e.flush, e.pc, e.ex);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output set mid-cycle.
  always @(negedge clk) begin
    if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
  end

  task automatic applyStimulus(input string name, input logic rst, v,
                               input logic [31:0] instr, input logic taken,
                               input logic eStall, eFlush, input logic [1:0] ePc,
                               input logic [36:0] eEx);
    exp_t e;
    reset           = rst;
    id_valid        = v;
    id_instr        = instr;
    ex_branch_taken = taken;
    e.name  = name;
    e.stall = eStall;
    e.flush = eFlush;
    e.pc    = ePc;
    e.ex    = eEx;
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_LW   = 32'h8E080000;
  localparam logic [31:0] I_ADD  = 32'h010A4820;
  localparam logic [31:0] I_LWZ  = 32'h8E000000;
  localparam logic [31:0] I_ADDZ = 32'h000A4820;
  localparam logic [31:0] I_ANDI = 32'h31280005;
  localparam logic [31:0] I_MUL  = 32'h710A4802;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_JAL  = 32'h0C000100;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_LWRA = 32'h8E1F0000;

  logic [36:0] exLw, exAdd, exLwz, exAddz, exAndi, exMul, exBeq, exJal, exJr, exLwra;
  logic [36:0] bub;

  initial begin
    bub    = '0;
    exLw   = exv(1,0,1,1,0,0,1,1,0, 2'd0, 2'd1, 4'b1000, 5'd16, 5'd8,  5'd0, 5'd0);
    exAdd  = exv(1,0,1,0,0,0,0,1,0, 2'd1, 2'd0, 4'b0010, 5'd8,  5'd10, 5'd9, 5'd0);
    exLwz  = exv(1,0,1,1,0,0,1,1,0, 2'd0, 2'd1, 4'b1000, 5'd16, 5'd0,  5'd0, 5'd0);
    exAddz = exv(1,0,1,0,0,0,0,1,0, 2'd1, 2'd0, 4'b0010, 5'd0,  5'd10, 5'd9, 5'd0);
    exAndi = exv(1,0,1,0,0,0,1,0,0, 2'd0, 2'd0, 4'b0100, 5'd9,  5'd8,  5'd0, 5'd0);
    exMul  = exv(1,0,1,0,0,0,0,1,0, 2'd1, 2'd0, 4'b0011, 5'd8,  5'd10, 5'd9, 5'd0);
    exBeq  = exv(1,1,0,0,0,0,0,1,0, 2'd0, 2'd0, 4'b0001, 5'd8,  5'd9,  5'd0, 5'd0);
    exJal  = exv(1,0,1,0,0,0,1,1,0, 2'd2, 2'd2, 4'b1000, 5'd0,  5'd0,  5'd0, 5'd4);
    exJr   = exv(1,0,0,0,0,0,0,1,0, 2'd1, 2'd0, 4'b0010, 5'd31, 5'd0,  5'd0, 5'd0);
    exLwra = exv(1,0,1,1,0,0,1,1,0, 2'd0, 2'd1, 4'b1000, 5'd16, 5'd31, 5'd0, 5'd0);

    reset = 1'b1; id_valid = 1'b0; id_instr = '0; ex_branch_taken = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("reset_state", 1, 0, 32'h0,  0, 0, 0, 2'b00, bub);

    applyStimulus("lu_lw",       0, 1, I_LW,   0, 0, 0, 2'b00, bub);
    applyStimulus("lu_stall",    0, 1, I_ADD,  0, 1, 0, 2'b00, exLw);
    applyStimulus("lu_bubble",   0, 1, I_ADD,  0, 0, 0, 2'b00, bub);
    applyStimulus("lu_add_ex",   0, 0, 32'h0,  0, 0, 0, 2'b00, exAdd);

    applyStimulus("z_lw",        0, 1, I_LWZ,  0, 0, 0, 2'b00, bub);
    applyStimulus("z_add",       0, 1, I_ADDZ, 0, 0, 0, 2'b00, exLwz);
    applyStimulus("z_add_ex",    0, 0, 32'h0,  0, 0, 0, 2'b00, exAddz);

    applyStimulus("rt_lw",       0, 1, I_LW,   0, 0, 0, 2'b00, bub);
    applyStimulus("rt_andi",     0, 1, I_ANDI, 0, 0, 0, 2'b00, exLw);
    applyStimulus("rt_andi_ex",  0, 0, 32'h0,  0, 0, 0, 2'b00, exAndi);

    applyStimulus("mul_issue",   0, 1, I_MUL,  0, 0, 0, 2'b00, bub);
`ifdef PIPE_CTRL_MUL_MULTICYCLE_EN
    for (int i = 0; i < 3; i++)
      applyStimulus("mul_hold",  0, 1, I_ADD,  0, 1, 0, 2'b00, exMul);
    applyStimulus("mul_release", 0, 1, I_ADD,  0, 0, 0, 2'b00, exMul);
`else
    applyStimulus("mul_pass",    0, 1, I_ADD,  0, 0, 0, 2'b00, exMul);
`endif
    applyStimulus("mul_next",    0, 0, 32'h0,  0, 0, 0, 2'b00, exAdd);

    applyStimulus("bt_issue",    0, 1, I_BEQ,  0, 0, 0, 2'b00, bub);
    applyStimulus("bt_flush",    0, 1, I_ADD,  1, 0, 1, 2'b00, exBeq);
    applyStimulus("bt_bubble",   0, 0, 32'h0,  0, 0, 0, 2'b00, bub);
    applyStimulus("bn_issue",    0, 1, I_BEQ,  0, 0, 0, 2'b00, bub);
    applyStimulus("bn_resolve",  0, 1, I_ADD,  0, 0, 0, 2'b00, exBeq);
    applyStimulus("bn_next",     0, 0, 32'h0,  0, 0, 0, 2'b00, exAdd);

    applyStimulus("jal_id",      0, 1, I_JAL,  0, 0, 1, 2'b01, bub);
    applyStimulus("jal_ex",      0, 0, 32'h0,  0, 0, 0, 2'b00, exJal);
    applyStimulus("jr_id",       0, 1, I_JR,   0, 0, 1, 2'b10, bub);
    applyStimulus("jr_ex",       0, 0, 32'h0,  0, 0, 0, 2'b00, exJr);

    applyStimulus("jr_lu_lw",    0, 1, I_LWRA, 0, 0, 0, 2'b00, bub);
    applyStimulus("jr_lu_stall", 0, 1, I_JR,   0, 1, 0, 2'b00, exLwra);
    applyStimulus("jr_lu_go",    0, 1, I_JR,   0, 0, 1, 2'b10, bub);
    applyStimulus("jr_lu_ex",    0, 0, 32'h0,  0, 0, 0, 2'b00, exJr);

    applyStimulus("rm_issue",    0, 1, I_MUL,  0, 0, 0, 2'b00, bub);
`ifdef PIPE_CTRL_MUL_MULTICYCLE_EN
    applyStimulus("rm_busy1",    0, 1, I_ADD,  0, 1, 0, 2'b00, exMul);
    applyStimulus("rm_busy2",    1, 1, I_ADD,  0, 1, 0, 2'b00, exMul);
`else
    applyStimulus("rm_busy1",    0, 1, I_ADD,  0, 0, 0, 2'b00, exMul);
    applyStimulus("rm_busy2",    1, 1, I_ADD,  0, 0, 0, 2'b00, exAdd);
`endif
    applyStimulus("rm_cleared",  0, 1, I_ADD,  0, 0, 0, 2'b00, bub);
    applyStimulus("rm_advance",  0, 0, 32'h0,  0, 0, 0, 2'b00, exAdd);

    for (int i = 0; i < 10 && scoreQ.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (scoreQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", scoreQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined successor to the single-cycle control decoder. Decodes the ID-stage MIPS instruction, registers the full control bundle into the ID/EX boundary, and owns the hazard logic the single-cycle design never needed: load-use stall, jump and taken-branch flush, and a parametrised multi-cycle multiply hold. Sits between the IF/ID register and the EX stage. Drives the PC/IF/ID hold and flush lines.

## Interface
Parameters:
- MUL_CYCLES, 4: EX occupancy of `mul` (opcode 0x1c), in cycles; legal range 1..15.
- ALUOP_W, 4: ALUOp width.
- REG_W, 5: register-index width.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  32  IF/ID instruction word.
- ex_branch_taken  in  1  the branch now in EX resolved taken; valid only while ex_branch=1.
- pc_src  out  2  combinational from ID: 2'b10 jr, 2'b01 j/jal, 2'b00 otherwise; forced to 0 while stall=1.
- stall  out  1  combinational; hold PC and IF/ID.
- flush_if_id  out  1  combinational; replace IF/ID with a bubble.
- ex_valid, ex_branch, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src1, ex_alu_src2, ex_ext_op, ex_lu_op  out  1 each  registered control bits.
- ex_reg_dst, ex_mem_to_reg  out  2 each  registered.
- ex_alu_op  out  ALUOP_W  registered.
- ex_rs, ex_rt, ex_rd  out  REG_W each  registered; ex_shamt  out  5  registered.

## Operation
- Decode uses the established single-cycle encoding.
  - R=0; jr = R with funct 8; shifts = funct 0/2/3, which sets alu_src1.
  - j=2, jal=3, beq=4, bne=5, bgtz=7, andi=0xc, slti/sltiu=0xa/0xb, lui=0xf, mul=0x1c, lw=0x23, sw=0x2b.
- ALUOp[2:0]: R 010, beq 001, bne 110, andi 100, mul 011, slti/sltiu 101, bgtz 111, else 000. ALUOp[3] = opcode[0].
- reg_dst: jal 2; R or mul 1; else 0.
- mem_to_reg: lw 1; jal 2; else 0.
- ext_op=0 only for andi. lu_op=1 only for lui.
- alu_src2=0 for R, beq, bne, mul; 1 otherwise.
- reg_write=0 for jr, j, beq, bne, bgtz, sw.
- Bubble: every ex_* bit 0, including ex_valid; index fields 0.
- Load-use hazard, all of the following hold:
  - ex_valid and ex_mem_read;
  - ex_rt != 0;
  - ex_rt == id rs, or (ex_rt == id rt and the ID op reads rt: R-type, beq, bne, sw, mul).
  - Response: stall=1 and insert a bubble into ID/EX.
- Mul hold: FSM IDLE/MULBUSY, 4-bit down-counter mul_cnt.
  - A valid mul enters EX with MUL_CYCLES>1: go to MULBUSY, load mul_cnt=MUL_CYCLES-1.
  - In MULBUSY: stall=1, ID/EX holds its contents, counter decrements. Return to IDLE when mul_cnt reaches 1.
- Jump (j, jal, jr) valid in ID and not stalled: flush_if_id=1; the jump itself proceeds into ID/EX.
- Taken branch: ex_branch and ex_branch_taken give flush_if_id=1, stall=0, and a bubble into ID/EX next edge.
- Priority: reset > taken-branch flush > mul hold > load-use bubble > jump flush > normal advance.
- A branch and a mul cannot share EX, so the taken-branch/mul-hold case is not reachable. The stated priority still governs it.

## Timing
- Decode-to-EX latency: 1 cycle. ID/EX updates every edge except during mul hold.
- Reset: all ex_* outputs 0, FSM IDLE, mul_cnt 0. Combinational outputs follow: stall=0, flush_if_id=0, pc_src=0.
- Load-use costs exactly 1 bubble. Mul costs MUL_CYCLES-1 stall cycles. Taken branch costs 2 slots. Jump costs 1 slot.
- Reset asserted mid-MULBUSY: IDLE and cleared bundle on that edge, with no residual stall.
- id_valid=0 decodes as a bubble and never raises hazard or flush.

## Configuration
- PIPE_CTRL_MUL_MULTICYCLE_EN defined: the mul hold FSM and counter behave as above.
- Undefined: FSM and counter are not built. mul passes through EX in one cycle with no stall, and MUL_CYCLES is ignored.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - opcode and funct localparams;
  - ALUOp code constants;
  - a packed struct ctrl_bundle_t covering all ex_* control bits;
  - the bubble constant CTRL_BUBBLE.
- Sub-module ctrl_decode: a purely combinational instruction-to-ctrl_bundle_t decoder, reused by the single-cycle top.
- Hazard logic, FSM and ID/EX register stay in pipe_ctrl_unit.

## Test plan
- `lw $t0,0($s0)` then `add $t1,$t0,$t2` -> one cycle with stall=1, one bubble (ex_valid=0), then add reaches EX with ex_alu_op=4'b0010.
- `lw $zero` then a dependent add -> no stall.
- `mul` with MUL_CYCLES=4 -> stall=1 for exactly 3 cycles and ex_alu_op=4'b0011 held. With the macro undefined, stall is never asserted.
- `beq` in EX with ex_branch_taken=1 -> flush_if_id=1, stall=0, next-cycle ex_valid=0.
- `jal` in ID -> pc_src=2'b01, flush_if_id=1, next-cycle ex_reg_dst=2, ex_mem_to_reg=2, ex_reg_write=1.
- `jr` in ID -> pc_src=2'b10 and flush_if_id=1, next-cycle ex_reg_write=0.
- reset pulsed during the second MULBUSY cycle -> next cycle all outputs 0 and the following instruction advances normally.
